// File: rtl/gauss5_pkg.sv
// rtl/gauss5_pkg.sv - shared widths, kernel coefficients and FSM states for gauss5_conv
package gauss5_pkg;

    localparam int ACC_W   = 16;
    localparam int RD_AW   = 15;
    localparam int WR_AW   = 14;
    localparam int TAP_CNT = 25;

    localparam logic [5:0] G [5] = '{6'd1, 6'd4, 6'd6, 6'd4, 6'd1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // Constant table lookup: w[k] = g[k/5] * g[k%5], folded to a 25-entry ROM.
    function automatic logic [5:0] tap_weight(input logic [4:0] k);
        logic [5:0] w;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (int'(k) == 5 * i + j) w = G[i] * G[j];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tap_addr_gen.sv
// rtl/tap_addr_gen.sv - pixel/tap counters with incremental padded and output addresses
module tap_addr_gen
    import gauss5_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step,
    input  logic             next_pix,
    output logic [RD_AW-1:0] rd_addr,
    output logic [WR_AW-1:0] wr_addr,
    output logic [4:0]       tap,
    output logic             last_tap,
    output logic             last_pixel
);

    localparam logic [RD_AW-1:0] ROW_STEP = RD_AW'(N);
    localparam logic [7:0]       LAST     = 8'(N - 1);

    logic [2:0]       j;
    logic [7:0]       r;
    logic [7:0]       c;
    logic [RD_AW-1:0] base;

    assign last_tap   = (tap == 5'(TAP_CNT - 1));
    assign last_pixel = (r == LAST) && (c == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            j       <= '0;
            tap     <= '0;
            r       <= '0;
            c       <= '0;
            base    <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else if (clear) begin
            j       <= '0;
            tap     <= '0;
            r       <= '0;
            c       <= '0;
            base    <= '0;
            rd_addr <= '0;
            wr_addr <= '0;
        end else begin
            if (step) begin
                if (last_tap) begin
                    j       <= '0;
                    tap     <= '0;
                    rd_addr <= base;
                end else begin
                    tap <= tap + 5'd1;
                    // Moving to the next kernel row skips the 4 columns beyond the window.
                    if (j == 3'd4) begin
                        j       <= '0;
                        rd_addr <= rd_addr + ROW_STEP;
                    end else begin
                        j       <= j + 3'd1;
                        rd_addr <= rd_addr + 15'd1;
                    end
                end
            end
            if (next_pix) begin
                wr_addr <= wr_addr + 14'd1;
                if (c == LAST) begin
                    c       <= '0;
                    r       <= r + 8'd1;
                    base    <= base + 15'd5;
                    rd_addr <= base + 15'd5;
                end else begin
                    c       <= c + 8'd1;
                    base    <= base + 15'd1;
                    rd_addr <= base + 15'd1;
                end
            end
        end
    end

endmodule

// File: rtl/gauss5_conv.sv
// rtl/gauss5_conv.sv - sequential 5x5 binomial blur from padded BRAM to output BRAM
module gauss5_conv
    import gauss5_pkg::*;
#(
    parameter int N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    output logic             done,
    output logic             busy,
    output logic             rd_en,
    output logic [RD_AW-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             wr_en,
    output logic [WR_AW-1:0] wr_addr,
    output logic [7:0]       wr_data
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] mac;
    logic [13:0]      prod;
    logic [4:0]       tap;
    logic [4:0]       w_idx;
    logic [5:0]       w;
    logic             last_tap;
    logic             last_pixel;

    tap_addr_gen #(.N(N)) u_addr (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == S_IDLE),
        .step       ((state == S_READ) && go),
        .next_pix   ((state == S_WRITE) && go && !last_pixel),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .tap        (tap),
        .last_tap   (last_tap),
        .last_pixel (last_pixel)
    );

    // Read data lags its address by one cycle, so the MAC uses the previous tap's weight.
    assign w_idx = (state == S_DRAIN) ? 5'(TAP_CNT - 1) : tap - 5'd1;
    assign w     = tap_weight(w_idx);
    assign prod  = {8'd0, w} * {6'd0, rd_data};
    assign mac   = acc + {2'b00, prod};

    assign busy    = (state == S_READ) || (state == S_DRAIN) || (state == S_WRITE);
    assign done    = (state == S_DONE);
    assign rd_en   = (state == S_READ);
    assign wr_en   = (state == S_WRITE) && go;
    assign wr_data = acc[15:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    acc <= '0;
                    if (go) state <= S_READ;
                end
                S_READ: begin
                    if (!go) begin
                        state <= S_IDLE;
                    end else begin
                        if (tap != 5'd0) acc <= mac;
                        if (last_tap) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!go) begin
                        state <= S_IDLE;
                    end else begin
                        acc   <= mac;
                        state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!go) begin
                        state <= S_IDLE;
                    end else if (last_pixel) begin
                        state <= S_DONE;
                    end else begin
                        acc   <= '0;
                        state <= S_READ;
                    end
                end
                S_DONE: begin
                    if (!go) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gauss5_conv.sv
// tb/tb_gauss5_conv.sv - scoreboard bench for gauss5_conv with N=16
module tb_gauss5_conv;

    localparam int N  = 16;
    localparam int P  = N + 4;
    localparam int NP = N * N;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        done;
    logic        busy;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;

    logic [7:0] mem [0:32767];
    int         out_img [NP];
    exp_t       sbq [$];
    exp_t       e;
    int         g [5] = '{1, 4, 6, 4, 1};
    int         cyc = 0;
    int         t0 = 0;
    int         rd_max = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    gauss5_conv #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .done    (done),
        .busy    (busy),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: every write pops one expectation (address, data, cycle of the write).
    always @(negedge clk) begin
        if (rst_n && rd_en && int'(rd_addr) > rd_max) rd_max = int'(rd_addr);
        if (rst_n && wr_en) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0d, expected no write", wr_addr, wr_data);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
                chk("wr_cycle", cyc - t0 + 1, e.cyc);
                out_img[wr_addr] = int'(wr_data);
            end
        end
    end

    function automatic int ref_pix(input int r, input int c);
        int s;
        s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                s += g[i] * g[j] * int'(mem[(r + i) * P + (c + j)]);
        return s >> 8;
    endfunction

    task automatic push_range(input int first, input int last);
        exp_t x;
        for (int a = first; a <= last; a++) begin
            x.addr = a;
            x.data = ref_pix(a / N, a % N);
            x.cyc  = 27 * a + 27;
            sbq.push_back(x);
        end
    endtask

    task automatic fill(input int kind);
        for (int y = 0; y < P; y++)
            for (int x = 0; x < P; x++) begin
                case (kind)
                    0: mem[y * P + x] = 8'd0;
                    1: mem[y * P + x] = (y >= 2 && y <= N + 1 && x >= 2 && x <= N + 1) ? 8'd100 : 8'd0;
                    2: mem[y * P + x] = (y == 10 && x == 10) ? 8'd255 : 8'd0;
                    default: mem[y * P + x] = 8'd255;
                endcase
            end
        for (int a = 0; a < NP; a++) out_img[a] = -1;
    endtask

    task automatic start();
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
    endtask

    task automatic wait_done();
        int n;
        for (n = 1; n <= 8000; n++) begin
            @(negedge clk);
            if (n == 1) chk("busy_first_cycle", int'(busy), 1);
            if (n == 27 * NP) chk("busy_last_cycle", int'(busy), 1);
            if (done) break;
        end
        chk("done_cycle", n, 27 * NP + 1);
        chk("busy_in_done", int'(busy), 0);
    endtask

    task automatic stop();
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        chk("done_after_go_low", int'(done), 0);
        chk("scoreboard_empty", sbq.size(), 0);
    endtask

    initial begin
        int n;
        for (int a = 0; a < 32768; a++) mem[a] = 8'd0;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_rd_addr", int'(rd_addr), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);
        chk("reset_wr_data", int'(wr_data), 0);

        // All-zero image
        fill(0);
        push_range(0, NP - 1);
        start();
        wait_done();
        @(negedge clk);
        chk("done_held_with_go", int'(done), 1);
        stop();

        // Interior 100, zero border
        fill(1);
        push_range(0, NP - 1);
        start();
        wait_done();
        stop();
        chk("out_7_7", out_img[7 * N + 7], 100);
        chk("out_0_0", out_img[0], 47);
        chk("out_0_7", out_img[7], 68);

        // Single 255 at padded (10,10)
        fill(2);
        push_range(0, NP - 1);
        start();
        wait_done();
        stop();
        chk("out_8_8", out_img[8 * N + 8], 35);
        chk("out_7_8", out_img[7 * N + 8], 23);
        chk("out_6_6", out_img[6 * N + 6], 0);

        // Saturated image, no overflow, address bound
        fill(3);
        rd_max = 0;
        push_range(0, NP - 1);
        start();
        wait_done();
        stop();
        chk("rd_addr_max", rd_max, P * P - 1);
        chk("out_last", out_img[NP - 1], 255);

        // Abort during pixel 3 READ, then restart from pixel 0
        fill(1);
        push_range(0, 2);
        start();
        repeat (89) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        repeat (60) @(negedge clk);
        chk("abort_scoreboard_empty", sbq.size(), 0);
        push_range(0, NP - 1);
        start();
        wait_done();
        stop();
        chk("restart_out_0_0", out_img[0], 47);

        // Asynchronous reset during the WRITE of pixel 5
        fill(2);
        push_range(0, 5);
        start();
        for (n = 0; n < 400; n++) begin
            @(negedge clk);
            if (wr_en && wr_addr == 14'd5) break;
        end
        chk("reached_write_5", n < 400 ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wr_en", int'(wr_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("rst_scoreboard_empty", sbq.size(), 0);
        repeat (2) @(negedge clk);
        push_range(0, NP - 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1 t0 = cyc;
        wait_done();
        stop();
        chk("rst_restart_out_8_8", out_img[8 * N + 8], 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gauss5_conv.md
# gauss5_conv

Downstream stage of the zero-padder: reads the (N+4)×(N+4) zero-padded 8-bit image from the padded BRAM and writes an N×N Gaussian-blurred image to an output BRAM. It applies a fixed, separable 5×5 binomial kernel. It uses a simple sequential engine: 25 reads per output pixel, one multiply-accumulate per read, then one write. Start and done follow the padder's `go`/`flag` convention, so the top level can chain the two stages.

## Interface
- `N`, default 16: input image side. Padded side is N+4. Legal range is 1..128 (output address fits 14 bits, padded address fits 15 bits).
- `clk` in, 1: single system clock. All logic runs on its rising edge.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `go` in, 1: level start. Must be held high for the whole run. Dropping it aborts the run.
- `done` out, 1: high after the last pixel is written. Held until `go` falls.
- `busy` out, 1: high in READ, DRAIN and WRITE.
- `rd_en` out, 1: padded BRAM read enable.
- `rd_addr` out, 15: padded BRAM address.
- `rd_data` in, 8: padded BRAM data. Valid exactly 1 cycle after its address is presented.
- `wr_en` out, 1: output BRAM write enable.
- `wr_addr` out, 14: output BRAM address, equal to r*N+c.
- `wr_data` out, 8: blurred pixel.

## Operation
- **Kernel:** w[i][j] = g[i]·g[j], with g = {1,4,6,4,1}. The kernel sums to 256.
- **Pixel value:** out(r,c) = (Σ w[i][j]·P[(r+i)*(N+4)+(c+j)]) >> 8, where P is the padded image.
  - The shift truncates; there is no rounding.
  - The maximum accumulated value is 255·256 = 65280, so the accumulator is 16 bits unsigned.
  - Saturation is never needed.
- **Pixel order:** raster, r outer, c inner. Within a pixel, taps are issued in raster order (i outer, j inner), tap index k = 5i+j.
- **Tap addresses:** generated incrementally, with no multiplier on the address path.
  - Next j: +1.
  - Next i: +(N+4)−4.
  - Pixel base: +1 per column; +5 at the end of each output row.
- **FSM states:** IDLE, READ, DRAIN, WRITE, DONE.
  - IDLE: counters cleared. If `go`=1, go to READ.
  - READ (25 cycles, k=0..24): `rd_en`=1 and `rd_addr`=tap k. From the second READ cycle, acc += w[k−1]·`rd_data`. Acc is cleared on entry. After k=24, go to DRAIN.
  - DRAIN (1 cycle): acc += w[24]·`rd_data`, `rd_en`=0. Then go to WRITE.
  - WRITE (1 cycle): `wr_en`=1, `wr_addr`=r*N+c, `wr_data`=acc[15:8].
    - If this is the last pixel, go to DONE.
    - Otherwise advance (r,c) and go to READ.
  - DONE: `done`=1, all enables 0. If `go`=0, go to IDLE.
- **Abort:** `go`=0 in READ, DRAIN or WRITE sends the FSM to IDLE on the next edge.
  - The cycle that samples `go`=0 issues no write.
  - Partial results are discarded. The next run restarts at pixel 0.
- **Reset:** `rst_n` low forces IDLE immediately, asynchronously, mid-run or not. All counters and acc go to 0.
- **Reset values:** `done`, `busy`, `rd_en` and `wr_en` are 0; `rd_addr`, `wr_addr` and `wr_data` are 0.
- **Unused BRAM ports:** read-side write enable and write-side read port are tied off at top level, not here.

## Timing
- Let cycle 0 be the edge that samples `go`=1 in IDLE.
- Pixel p occupies cycles 27p+1 through 27p+27:
  - READ at 27p+1..27p+25.
  - DRAIN at 27p+26.
  - WRITE at 27p+27.
- `done` rises at cycle 27·N²+1. For N=16 that is cycle 6913.
- `busy` is high from cycle 1 through 27·N², inclusive.
- Exactly one `wr_en` pulse per pixel. Pulses are 27 cycles apart, with strictly increasing `wr_addr` 0..N²−1.
- `rd_en` is asserted only in READ. `rd_addr` never exceeds (N+4)²−1.
- `go` held high after DONE does not restart the run. `go` must fall and rise again.

## Structure
- **Package `gauss5_pkg`:**
  - g[] coefficient constant array.
  - FSM state enum.
  - Widths: ACC_W=16, RD_AW=15, WR_AW=14, TAP_CNT=25.
- **Sub-module `tap_addr_gen`:** owns the (r,c,i,j) counters and incremental address arithmetic. Outputs `rd_addr`, `wr_addr`, tap index, last_tap and last_pixel.
- **Top FSM:** owns the MAC, acc and handshakes.
- **Weight lookup:** w = g[i]·g[j] from a combinational constant lookup. No runtime multiplier is needed for weights; only the 8×6-bit MAC product.

## Test plan
- Padded image all 0, N=16, `go` high → 256 writes, all `wr_data`=0, `done` rises at cycle 6913.
- Interior (padded 2..17) all 100, border 0 → out(7,7)=100; out(0,0)=(121·100)>>8=47; out(0,7)=(11·16·100)>>8=68.
- Single padded pixel 255 at (10,10), rest 0 → out(8,8)=(36·255)>>8=35; out(7,8)=(24·255)>>8=23; out(6,6)=(1·255)>>8=0.
- Whole padded image 255 → every `wr_data`=255 (no overflow). `rd_addr` maximum observed is 399.
- Drop `go` during pixel 3's READ → no further `wr_en`, IDLE next cycle. Raising `go` again → first write has `wr_addr`=0 with a correct value.
- Assert `rst_n`=0 mid-WRITE → `wr_en`, `busy` and `done` go to 0 asynchronously. After release with `go` high, the run restarts from pixel 0.
